// File: rtl/fir_pkg.sv
// Shared widths, limits and types for the FIR output requantiser.
package fir_pkg;
  localparam int ACC_W       = 22;
  localparam int SAMPLE_W    = 12;
  localparam int ACC_FRAC    = 18;
  localparam int SAMPLE_FRAC = 10;

  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 12'h7FF;
  localparam logic [SAMPLE_W-1:0] SAMPLE_MIN = 12'h800;

  typedef logic signed [ACC_W-1:0]    acc_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/fir_out_requant_sync_fifo.sv
// Power-of-2 synchronous FIFO; a push while full is accepted
// only when a pop happens on the same edge.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int W     = SAMPLE_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk100,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] fill
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign fill    = cnt;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk100) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        cnt <= cnt + 1'b1;
      else if (!do_push && do_pop)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk100) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fir_out_requant.sv
// Requantise FIR accumulator to Q.10 samples, buffered for the sink.
// Optional sat_count port: define FIR_REQUANT_SATCNT_EN.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = SAMPLE_W,
  parameter int SHIFT = ACC_FRAC - SAMPLE_FRAC,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk100,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             sat_pulse,
  output logic             ovf_pulse,
`ifdef FIR_REQUANT_SATCNT_EN
  output logic [CNT_W-1:0] fill,
  output logic [15:0]      sat_count
`else
  output logic [CNT_W-1:0] fill
`endif
);
  localparam int SW = IN_W + 1;
  localparam int QW = SW - SHIFT;
  localparam int QMAX_I = (1 << (OUT_W - 1)) - 1;
  localparam int QMIN_I = -(1 << (OUT_W - 1));

  localparam logic signed [QW-1:0] QMAX = QW'(QMAX_I);
  localparam logic signed [QW-1:0] QMIN = QW'(QMIN_I);
  localparam logic [SW-1:0] RND = SW'(1) << (SHIFT - 1);
  localparam logic [OUT_W-1:0] RMAX =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] RMIN =
    {1'b1, {(OUT_W-1){1'b0}}};

  logic                    v1;
  logic signed [SW-1:0]    sum;
  logic signed [QW-1:0]    q;
  logic [OUT_W-1:0]        res_c;
  logic                    sat_c;
  logic                    v2;
  logic                    sat2;
  logic [OUT_W-1:0]        res2;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic                    sat_wr;

  // Extra sign bit keeps the rounding add from wrapping at +max.
  always_ff @(posedge clk100) begin
    if (!rstn) begin
      v1  <= 1'b0;
      sum <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid)
        sum <= {in_data[IN_W-1], in_data} + RND;
    end
  end

  assign q = $signed(sum[SW-1:SHIFT]);

  always_comb begin
    sat_c = 1'b0;
    res_c = q[OUT_W-1:0];
    unique case (1'b1)
      (q > QMAX): begin
        sat_c = 1'b1;
        res_c = RMAX;
      end
      (q < QMIN): begin
        sat_c = 1'b1;
        res_c = RMIN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (!rstn) begin
      v2   <= 1'b0;
      sat2 <= 1'b0;
      res2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        sat2 <= sat_c;
        res2 <= res_c;
      end
    end
  end

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign sat_wr    = v2 & sat2 & (~full | pop);

  always_ff @(posedge clk100) begin
    if (!rstn) begin
      sat_pulse <= 1'b0;
      ovf_pulse <= 1'b0;
    end else begin
      sat_pulse <= sat_wr;
      ovf_pulse <= v2 & full & ~pop;
    end
  end

`ifdef FIR_REQUANT_SATCNT_EN
  always_ff @(posedge clk100) begin
    if (!rstn)
      sat_count <= '0;
    else if (sat_wr && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end
`endif

  sync_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk100 (clk100),
    .rstn   (rstn),
    .push   (v2),
    .pop    (pop),
    .din    (res2),
    .dout   (out_data),
    .full   (full),
    .empty  (empty),
    .fill   (fill)
  );
endmodule
